// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port.
// Two sources, LOAD (port 0) and ALU (port 1), each park one request in a
// holding buffer. One registered write is issued per cycle. Entries with the
// same destination go out in program order. Otherwise a round-robin pointer
// alternates between the ports. pendMask reports which destinations are still
// buffered so the hazard logic can stall readers of those registers.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ldValid,
    output logic                     ldReady,
    input  logic [ADDR_W-1:0]        ldRd,
    input  logic [DATA_W-1:0]        ldData,
    input  logic                     aluValid,
    output logic                     aluReady,
    input  logic [ADDR_W-1:0]        aluRd,
    input  logic [DATA_W-1:0]        aluData,
    output logic                     writeEnable,
    output logic [ADDR_W-1:0]        rd,
    output logic [DATA_W-1:0]        din,
    output logic [(1<<ADDR_W)-1:0]   pendMask
);

    localparam int NREG = 1 << ADDR_W;

    // Which port the round-robin pointer favours on the next contested grant
    typedef enum logic {
        RR_LOAD = 1'b0,
        RR_ALU  = 1'b1
    } rr_e;

    // Holding buffers
    logic              ld_full_q,  ld_full_d;
    logic [ADDR_W-1:0] ld_rd_q,    ld_rd_d;
    logic [DATA_W-1:0] ld_data_q,  ld_data_d;
    logic              alu_full_q, alu_full_d;
    logic [ADDR_W-1:0] alu_rd_q,   alu_rd_d;
    logic [DATA_W-1:0] alu_data_q, alu_data_d;

    // Arbitration state. ld_older_q means the LOAD entry was captured first.
    rr_e               rr_q, rr_d;
    logic              ld_older_q, ld_older_d;

    // Registered write port and hazard mask
    logic              we_q, we_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [NREG-1:0]   pend_q, pend_d;

    logic grant_ld;
    logic grant_alu;
    logic ld_acc;
    logic alu_acc;

    // Pick this cycle's winner. The pointer only moves when it decides a contest.
    always_comb begin
        grant_ld  = 1'b0;
        grant_alu = 1'b0;
        rr_d      = rr_q;
        if (ld_full_q && alu_full_q) begin
            if (ld_rd_q == alu_rd_q) begin
                grant_ld  = ld_older_q;
                grant_alu = !ld_older_q;
            end else begin
                grant_ld  = (rr_q == RR_LOAD);
                grant_alu = (rr_q == RR_ALU);
                rr_d      = (rr_q == RR_LOAD) ? RR_ALU : RR_LOAD;
            end
        end else begin
            grant_ld  = ld_full_q;
            grant_alu = alu_full_q;
        end
    end

    // A buffer can take a request if it is empty or is draining this cycle
    always_comb begin
        ldReady  = !ld_full_q  || grant_ld;
        aluReady = !alu_full_q || grant_alu;
        ld_acc   = ldValid  && ldReady;
        alu_acc  = aluValid && aluReady;
    end

    // Next buffer contents, age tracking, issued write and pending mask
    always_comb begin
        ld_full_d  = ld_acc ? 1'b1 : (grant_ld ? 1'b0 : ld_full_q);
        ld_rd_d    = ld_acc ? ldRd : ld_rd_q;
        ld_data_d  = ld_acc ? ldData : ld_data_q;
        alu_full_d = alu_acc ? 1'b1 : (grant_alu ? 1'b0 : alu_full_q);
        alu_rd_d   = alu_acc ? aluRd : alu_rd_q;
        alu_data_d = alu_acc ? aluData : alu_data_q;

        ld_older_d = ld_older_q;
        if (ld_acc && alu_acc) begin
            ld_older_d = 1'b1;
        end else if (ld_acc) begin
            ld_older_d = 1'b0;
        end else if (alu_acc) begin
            ld_older_d = 1'b1;
        end

        we_d  = 1'b0;
        rd_d  = rd_q;
        din_d = din_q;
        if (grant_ld) begin
            we_d  = (ld_rd_q != '0);
            rd_d  = ld_rd_q;
            din_d = ld_data_q;
        end else if (grant_alu) begin
            we_d  = (alu_rd_q != '0);
            rd_d  = alu_rd_q;
            din_d = alu_data_q;
        end

        pend_d = '0;
        if (ld_full_d) begin
            pend_d = pend_d | (NREG'(1) << ld_rd_d);
        end
        if (alu_full_d) begin
            pend_d = pend_d | (NREG'(1) << alu_rd_d);
        end
    end

    // State registers. Reset drops any buffered entries without writing them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_full_q  <= 1'b0;
            ld_rd_q    <= '0;
            ld_data_q  <= '0;
            alu_full_q <= 1'b0;
            alu_rd_q   <= '0;
            alu_data_q <= '0;
            rr_q       <= RR_LOAD;
            ld_older_q <= 1'b0;
            we_q       <= 1'b0;
            rd_q       <= '0;
            din_q      <= '0;
            pend_q     <= '0;
        end else begin
            ld_full_q  <= ld_full_d;
            ld_rd_q    <= ld_rd_d;
            ld_data_q  <= ld_data_d;
            alu_full_q <= alu_full_d;
            alu_rd_q   <= alu_rd_d;
            alu_data_q <= alu_data_d;
            rr_q       <= rr_d;
            ld_older_q <= ld_older_d;
            we_q       <= we_d;
            rd_q       <= rd_d;
            din_q      <= din_d;
            pend_q     <= pend_d;
        end
    end

    assign writeEnable = we_q;
    assign rd          = rd_q;
    assign din         = din_q;
    assign pendMask    = pend_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic,
// every cycle compared against a sequence-number based reference model.
module tb_regfile_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              ldValid;
    logic              ldReady;
    logic [ADDR_W-1:0] ldRd;
    logic [DATA_W-1:0] ldData;
    logic              aluValid;
    logic              aluReady;
    logic [ADDR_W-1:0] aluRd;
    logic [DATA_W-1:0] aluData;
    logic              writeEnable;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] din;
    logic [NREG-1:0]   pendMask;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: each port holds at most one entry stamped with an
    // arrival number; smaller number = older. turn=0 favours LOAD next.
    bit                m_ld_v, m_alu_v;
    logic [ADDR_W-1:0] m_ld_rd, m_alu_rd;
    logic [DATA_W-1:0] m_ld_data, m_alu_data;
    int                m_ld_seq, m_alu_seq;
    int                m_seq;
    int                m_turn;
    bit                e_we;
    logic [ADDR_W-1:0] e_rd;
    logic [DATA_W-1:0] e_din;
    logic [NREG-1:0]   e_pend;

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .ldValid     (ldValid),
        .ldReady     (ldReady),
        .ldRd        (ldRd),
        .ldData      (ldData),
        .aluValid    (aluValid),
        .aluReady    (aluReady),
        .aluRd       (aluRd),
        .aluData     (aluData),
        .writeEnable (writeEnable),
        .rd          (rd),
        .din         (din),
        .pendMask    (pendMask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ld_v  = 0;
        m_alu_v = 0;
        m_seq   = 0;
        m_turn  = 0;
        e_we    = 0;
        e_rd    = '0;
        e_din   = '0;
        e_pend  = '0;
    endtask

    // One cycle, entered and left 1 time unit after a rising edge: check the
    // outputs of the previous edge, drive new requests, advance the model.
    task automatic apply_stimulus(input bit lv, input logic [ADDR_W-1:0] lr, input logic [DATA_W-1:0] ldat,
                                  input bit av, input logic [ADDR_W-1:0] ar, input logic [DATA_W-1:0] adat);
        int  g;
        bit  exp_ldr, exp_alur;
        ldValid  = lv;
        ldRd     = lr;
        ldData   = ldat;
        aluValid = av;
        aluRd    = ar;
        aluData  = adat;

        g = 0;
        if (m_ld_v && m_alu_v) begin
            if (m_ld_rd == m_alu_rd) begin
                g = (m_ld_seq < m_alu_seq) ? 1 : 2;
            end else begin
                g = (m_turn == 0) ? 1 : 2;
                m_turn = (g == 1) ? 1 : 0;
            end
        end else if (m_ld_v) begin
            g = 1;
        end else if (m_alu_v) begin
            g = 2;
        end
        exp_ldr  = !m_ld_v  || g == 1;
        exp_alur = !m_alu_v || g == 2;

        #1;
        check_output("ldReady",     ldReady,     exp_ldr);
        check_output("aluReady",    aluReady,    exp_alur);
        check_output("writeEnable", writeEnable, e_we);
        check_output("rd",          rd,          e_rd);
        check_output("din",         din,         e_din);
        check_output("pendMask",    pendMask,    e_pend);

        e_we = 0;
        if (g == 1) begin
            e_we = (m_ld_rd != 0);
            e_rd = m_ld_rd;
            e_din = m_ld_data;
            m_ld_v = 0;
        end else if (g == 2) begin
            e_we = (m_alu_rd != 0);
            e_rd = m_alu_rd;
            e_din = m_alu_data;
            m_alu_v = 0;
        end
        if (lv && exp_ldr) begin
            m_ld_v = 1; m_ld_rd = lr; m_ld_data = ldat; m_ld_seq = m_seq; m_seq++;
        end
        if (av && exp_alur) begin
            m_alu_v = 1; m_alu_rd = ar; m_alu_data = adat; m_alu_seq = m_seq; m_seq++;
        end
        e_pend = '0;
        if (m_ld_v)  e_pend[m_ld_rd]  = 1'b1;
        if (m_alu_v) e_pend[m_alu_rd] = 1'b1;

        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(0, '0, '0, 0, '0, '0);
    endtask

    initial begin
        model_reset();
        rst      = 1'b0;
        ldValid  = 1'b1;
        ldRd     = 5'd3;
        ldData   = 32'd5;
        aluValid = 1'b1;
        aluRd    = 5'd4;
        aluData  = 32'd6;

        // Reset held with both requests valid
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_we",       writeEnable, 1'b0);
        check_output("rst_pend",     pendMask,    '0);
        check_output("rst_ldReady",  ldReady,     1'b1);
        check_output("rst_aluReady", aluReady,    1'b1);
        ldValid  = 1'b0;
        aluValid = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        // Single uncontended ALU write to r1
        apply_stimulus(0, '0, '0, 1, 5'd1, 32'd1234);
        check_output("single_pend1", pendMask[1], 1'b1);
        check_output("single_we0",   writeEnable, 1'b0);
        apply_stimulus(0, '0, '0, 0, '0, '0);
        check_output("single_we",   writeEnable, 1'b1);
        check_output("single_rd",   rd,          5'd1);
        check_output("single_din",  din,         32'd1234);
        check_output("single_pend", pendMask,    '0);
        idle(1);

        // Simultaneous LOAD and ALU: LOAD first, then ALU; next contest ALU first
        apply_stimulus(1, 5'd2, 32'd6666, 1, 5'd10, 32'd7777);
        check_output("cont_aluReady", aluReady, 1'b0);
        check_output("cont_ldReady",  ldReady,  1'b1);
        apply_stimulus(0, '0, '0, 0, '0, '0);
        check_output("cont_first_rd",  rd,  5'd2);
        check_output("cont_first_din", din, 32'd6666);
        apply_stimulus(0, '0, '0, 0, '0, '0);
        check_output("cont_second_rd",  rd,  5'd10);
        check_output("cont_second_din", din, 32'd7777);
        apply_stimulus(1, 5'd3, 32'd111, 1, 5'd4, 32'd222);
        apply_stimulus(0, '0, '0, 0, '0, '0);
        check_output("rr_alu_first_din", din, 32'd222);
        apply_stimulus(0, '0, '0, 0, '0, '0);
        check_output("rr_ld_second_din", din, 32'd111);

        // Same destination, ALU one cycle ahead of LOAD
        apply_stimulus(0, '0, '0, 1, 5'd11, 32'd2021);
        apply_stimulus(1, 5'd11, 32'd2022, 0, '0, '0);
        check_output("hazard_first_din", din, 32'd2021);
        apply_stimulus(0, '0, '0, 0, '0, '0);
        check_output("hazard_second_din", din, 32'd2022);

        // Contest leaves ALU parked; a newer LOAD to the same rd must wait behind it
        apply_stimulus(1, 5'd5, 32'd501, 1, 5'd6, 32'd601);
        apply_stimulus(1, 5'd6, 32'd502, 0, '0, '0);
        idle(3);

        // Write to r0 is consumed without a strobe
        apply_stimulus(0, '0, '0, 1, 5'd0, 32'd99);
        apply_stimulus(0, '0, '0, 0, '0, '0);
        check_output("r0_we",   writeEnable, 1'b0);
        check_output("r0_pend", pendMask,    '0);
        idle(1);

        // Asynchronous reset while both buffers hold entries
        apply_stimulus(1, 5'd7, 32'd70, 1, 5'd8, 32'd80);
        ldValid  = 1'b0;
        aluValid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_output("arst_we",   writeEnable, 1'b0);
        check_output("arst_rd",   rd,          '0);
        check_output("arst_din",  din,         '0);
        check_output("arst_pend", pendMask,    '0);
        #2 rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        idle(3);

        // Random traffic with a narrow rd range so same-rd contests are common
        for (int i = 0; i < 400; i++) begin
            apply_stimulus($urandom_range(0, 1), ADDR_W'($urandom_range(0, 3)), $urandom,
                           $urandom_range(0, 1), ADDR_W'($urandom_range(0, 3)), $urandom);
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
